// File: rtl/rect_char_buffer.sv
// rect_char_buffer: cursor-addressed ROWS x COLS character buffer with a 1-cycle read port and self-timed clear
module rect_char_buffer #(
   parameter int         ROWS      = 16,
   parameter int         COLS      = 16,
   parameter logic [6:0] FILL_CHAR = 7'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_xy,
   output logic [6:0] char_code,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       busy,
   output logic [7:0] cursor_xy
);
   typedef enum logic {S_CLEAR, S_IDLE} state_t;
   localparam logic [1:0] OP_PUTC = 2'b00, OP_NL = 2'b01, OP_SETPOS = 2'b10, OP_CLEAR = 2'b11;
   state_t state;
   logic [6:0] mem [256];
   logic [7:0] clr_cnt, waddr, raddr;
   logic [6:0] wdata;
   logic [3:0] row, col, nrow, ncol, srow, scol;
   logic acc, we, rd_ok;
   assign cursor_xy = {row, col};
   // write-port selection, cursor arithmetic and read-address mapping
   always_comb begin
      acc = cmd_valid && cmd_ready;
      we = !rst && (state == S_CLEAR || (acc && cmd_op == OP_PUTC));
      waddr = state == S_CLEAR ? clr_cnt : {4'd0, row} * 8'(COLS) + {4'd0, col};
      wdata = state == S_CLEAR ? FILL_CHAR : cmd_data[6:0];
      ncol = col == 4'(COLS - 1) ? 4'd0 : col + 4'd1;
      nrow = row == 4'(ROWS - 1) ? 4'd0 : row + 4'd1;
      srow = {1'b0, cmd_data[7:4]} < 5'(ROWS) ? cmd_data[7:4] : 4'(ROWS - 1);
      scol = {1'b0, cmd_data[3:0]} < 5'(COLS) ? cmd_data[3:0] : 4'(COLS - 1);
      rd_ok = {1'b0, char_xy[7:4]} < 5'(ROWS) && {1'b0, char_xy[3:0]} < 5'(COLS);
      raddr = {4'd0, char_xy[7:4]} * 8'(COLS) + {4'd0, char_xy[3:0]};
   end
   // clear engine, command handling and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_CLEAR;
         clr_cnt <= 8'd0;
         row <= 4'd0;
         col <= 4'd0;
         cmd_ready <= 1'b0;
         busy <= 1'b1;
      end else if (state == S_CLEAR) begin
         clr_cnt <= clr_cnt + 8'd1;
         if (clr_cnt == 8'(ROWS * COLS - 1)) begin
            state <= S_IDLE;
            cmd_ready <= 1'b1;
            busy <= 1'b0;
         end
      end else if (acc) begin
         case (cmd_op)
            OP_PUTC: begin
               col <= ncol;
               row <= col == 4'(COLS - 1) ? nrow : row;
            end
            OP_NL: begin
               col <= 4'd0;
               row <= nrow;
            end
            OP_SETPOS: begin
               row <= srow;
               col <= scol;
            end
            default: begin
               state <= S_CLEAR;
               clr_cnt <= 8'd0;
               row <= 4'd0;
               col <= 4'd0;
               cmd_ready <= 1'b0;
               busy <= 1'b1;
            end
         endcase
      end
   end
   // single write port; memory contents are not reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   // read-first registered read; out-of-range coordinates return the fill code
   always_ff @(posedge clk) begin
      char_code <= rst ? 7'd0 : rd_ok ? mem[raddr] : FILL_CHAR;
   end
endmodule

// File: tb/tb_rect_char_buffer.sv
// tb_rect_char_buffer: scoreboard bench for the character buffer at default and 4x10 geometries
module tb_rect_char_buffer;
   logic clk = 0, rst = 1, b_rst = 1;
   logic [7:0] char_xy = 0, cmd_data = 0, cursor_xy, b_xy = 0, b_data = 0, b_cursor;
   logic [6:0] char_code, b_code;
   logic cmd_valid = 0, b_valid = 0, cmd_ready, b_ready, busy, b_busy;
   logic [1:0] cmd_op = 0, b_op = 0;
   int cyc = 0, passed = 0, total = 0;
   typedef struct {int cyc; int kind; logic [31:0] exp; string name;} exp_t;
   exp_t q[$];

   rect_char_buffer dut (
      .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(char_code),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .busy(busy), .cursor_xy(cursor_xy)
   );
   rect_char_buffer #(.ROWS(4), .COLS(10), .FILL_CHAR(7'h20)) dut_b (
      .clk(clk), .rst(b_rst), .char_xy(b_xy), .char_code(b_code),
      .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
      .cmd_data(b_data), .busy(b_busy), .cursor_xy(b_cursor)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pick(int k);
      case (k)
         0: pick = {25'd0, char_code};
         1: pick = {24'd0, cursor_xy};
         2: pick = {31'd0, cmd_ready};
         3: pick = {31'd0, busy};
         4: pick = {25'd0, b_code};
         5: pick = {24'd0, b_cursor};
         default: pick = {31'd0, b_ready};
      endcase
   endfunction

   function void chk(string n, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", n, act, exp, cyc);
   endfunction

   task push(int d, int k, logic [31:0] e, string n);
      q.push_back('{cyc + d, k, e, n});
   endtask

   always @(negedge clk) begin
      while (q.size() != 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         if (e.cyc != cyc) begin
            total++;
            $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
         end else chk(e.name, pick(e.kind), e.exp);
      end
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task wait_ready(input int which, output int n);
      n = 0;
      while (!(which == 0 ? cmd_ready : b_ready) && n < 2000) begin
         tick;
         n++;
      end
      if (n >= 2000) begin
         total++;
         $display("FAIL ready_timeout: waited %0d cycles, required under 2000", n);
      end
   endtask

   task send(input int which, input logic [1:0] op, input logic [7:0] d, output int n);
      if (which == 0) begin
         cmd_valid = 1; cmd_op = op; cmd_data = d;
      end else begin
         b_valid = 1; b_op = op; b_data = d;
      end
      wait_ready(which, n);
      tick;
      cmd_valid = 0;
      b_valid = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int w;
      tick;
      push(0, 2, 0, "rst_ready"); push(0, 3, 1, "rst_busy");
      push(0, 1, 0, "rst_cursor"); push(0, 0, 0, "rst_code");
      tick;
      rst = 0;
      wait_ready(0, w);
      chk("ready_latency", w, 256);
      push(0, 3, 0, "idle_busy"); push(0, 1, 0, "idle_cursor");
      for (int a = 0; a < 256; a++) begin
         char_xy = 8'(a);
         push(1, 0, 32'h20, "sweep_fill");
         tick;
      end
      send(0, 2'b10, 8'h25, w);
      send(0, 2'b00, 8'h41, w);
      push(0, 1, 32'h26, "putc_cursor");
      char_xy = 8'h25; push(1, 0, 32'h41, "putc_read"); tick;
      char_xy = 8'h24; push(1, 0, 32'h20, "neighbor_read"); tick;
      send(0, 2'b10, 8'hFF, w);
      send(0, 2'b00, 8'h42, w);
      send(0, 2'b00, 8'h43, w);
      push(0, 1, 32'h01, "wrap_cursor");
      char_xy = 8'hFF; push(1, 0, 32'h42, "wrap_cell_ff"); tick;
      char_xy = 8'h00; push(1, 0, 32'h43, "wrap_cell_00"); tick;
      send(0, 2'b10, 8'h37, w);
      send(0, 2'b01, 8'h00, w);
      push(0, 1, 32'h40, "newline_mid");
      send(0, 2'b10, 8'hF3, w);
      send(0, 2'b01, 8'h00, w);
      push(0, 1, 32'h00, "newline_wrap");
      send(0, 2'b11, 8'h00, w);
      push(0, 2, 0, "clr_ready_first"); push(0, 3, 1, "clr_busy_first");
      push(255, 2, 0, "clr_ready_last"); push(255, 3, 1, "clr_busy_last");
      push(256, 2, 1, "clr_ready_end"); push(256, 3, 0, "clr_busy_end");
      send(0, 2'b00, 8'h44, w);
      chk("stall_cycles", w, 256);
      push(0, 1, 32'h01, "stall_cursor");
      char_xy = 8'h00; push(1, 0, 32'h44, "stall_cell_00"); tick;
      char_xy = 8'hFF; push(1, 0, 32'h20, "cleared_ff"); tick;
      send(0, 2'b11, 8'h00, w);
      repeat (100) tick;
      rst = 1;
      tick; tick;
      rst = 0;
      push(0, 1, 0, "midclr_cursor");
      wait_ready(0, w);
      chk("restart_latency", w, 256);
      send(0, 2'b10, 8'h25, w);
      char_xy = 8'h25;
      push(1, 0, 32'h20, "collide_old");
      push(2, 0, 32'h77, "collide_new");
      send(0, 2'b00, 8'h77, w);
      tick; tick;
      b_rst = 0;
      wait_ready(1, w);
      chk("b_clear_len", w, 40);
      send(1, 2'b10, 8'h9F, w);
      push(0, 5, 32'h39, "b_setpos_clamp");
      b_xy = 8'h0A; push(1, 4, 32'h20, "b_oob_col"); tick;
      b_xy = 8'h40; push(1, 4, 32'h20, "b_oob_row"); tick;
      send(1, 2'b00, 8'h45, w);
      push(0, 5, 32'h00, "b_wrap");
      b_xy = 8'h39; push(1, 4, 32'h45, "b_cell_39"); tick;
      b_xy = 8'h09; push(1, 4, 32'h20, "b_cell_09"); tick;
      repeat (3) tick;
      if (q.size() != 0) begin
         total++;
         $display("FAIL scoreboard_drain: %0d pending, required 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/rect_char_buffer.md
Name: rect_char_buffer

Overview:
- Character-cell text buffer feeding the character-rectangle draw stage.
- Holds ROWS x COLS 7-bit character codes.
- Draw side: the draw stage supplies char_xy; the buffer returns char_code one clock later. The font ROM then turns char_code plus char_line into char_pixels.
- Write side: a cursor-based command port with valid/ready handshake, used by game logic to print text.
- Includes a self-timed clear engine.

Parameters:
- ROWS, 16, number of text rows (1..16); row index is char_xy[7:4].
- COLS, 16, number of text columns (1..16); column index is char_xy[3:0].
- FILL_CHAR, 7'h20, code written by CLEAR and returned for out-of-range reads.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- char_xy  in  8  read address {row[3:0], col[3:0]} from draw stage.
- char_code  out  7  character code at char_xy, registered.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  2  00 PUTC, 01 NEWLINE, 10 SETPOS, 11 CLEAR.
- cmd_data  in  8  PUTC: code in [6:0], bit 7 ignored; SETPOS: {row[3:0], col[3:0]}; otherwise ignored.
- busy  out  1  high while the clear engine runs.
- cursor_xy  out  8  current cursor {row, col}.

Behaviour:

Reset and clear entry
- Memory is not reset directly.
- rst high forces: state CLEAR, clear counter 0, cursor 0, char_code 0, cmd_ready 0, busy 1.

States
- CLEAR:
  - Each cycle writes FILL_CHAR to cell clr_cnt (row = clr_cnt / COLS, col = clr_cnt % COLS) and increments clr_cnt.
  - After writing cell ROWS*COLS-1, goes to IDLE on the next edge.
  - First cmd_ready=1 occurs exactly ROWS*COLS cycles after rst deasserts (256 with defaults).
  - cmd_ready=0 and busy=1 throughout.
- IDLE: cmd_ready=1, busy=0. A command is accepted on a clock edge where cmd_valid && cmd_ready. Effects are visible on the following cycle.
  - PUTC: writes cmd_data[6:0] at cursor, then advances the cursor.
    - col+1 normally.
    - At col=COLS-1: col=0, row+1.
    - At row=ROWS-1 with col=COLS-1: wraps to (0,0); no scrolling.
  - NEWLINE: col=0; row+1, wrapping ROWS-1 -> 0. No memory write.
  - SETPOS: row = min(cmd_data[7:4], ROWS-1); col = min(cmd_data[3:0], COLS-1).
  - CLEAR: cursor=0, clr_cnt=0, next state CLEAR.
- Commands presented while cmd_ready=0 are not consumed. The sender holds cmd_valid and the command stable until accepted.
- rst in the middle of a clear restarts the clear from cell 0.

Read port
- One write port plus one independent read port, e.g. simple dual-port RAM.
- char_code(t+1) = mem[char_xy(t)]: fixed 1-cycle latency, every cycle, in every state.
- If char_xy row >= ROWS or col >= COLS, char_code(t+1) = FILL_CHAR.
- Read and write to the same cell in the same cycle: read returns the old contents (read-first).
- During CLEAR, reads return partially cleared contents. This is acceptable; no stall.

Widths
- Cursor row/col are 4 bits each; cursor_xy = {row, col}.
- Memory index = row*COLS + col, 8 bits.

Test Plan:
1. Reset then idle:
   - Stimulus: rst for 2 cycles, then sweep char_xy over all 256 addresses after cmd_ready rises.
   - Required: cmd_ready rises exactly 256 cycles after rst falls; every char_code=7'h20; cursor_xy=8'h00.
2. PUTC and read latency:
   - Stimulus: SETPOS 8'h25, then PUTC 'A' (7'h41).
   - Required: cursor_xy=8'h26.
   - Required: char_xy=8'h25 at cycle t gives char_code=7'h41 at t+1; char_xy=8'h24 gives 7'h20.
3. Wrap:
   - Stimulus: SETPOS 8'hFF, PUTC 7'h42, PUTC 7'h43.
   - Required: cell FF=7'h42, cell 00=7'h43, cursor_xy=8'h01.
   - Stimulus: NEWLINE from row F.
   - Required: row 0, col 0.
4. Handshake stall:
   - Stimulus: issue CLEAR, then hold PUTC 7'h44 valid from the next cycle.
   - Required: cmd_ready=0 and busy=1 for 256 cycles; the PUTC is accepted on the first ready cycle; 7'h44 lands at cell 00; cursor_xy=8'h01.
5. Parameters and boundaries, ROWS=4, COLS=10:
   - Stimulus: SETPOS 8'h9F.
   - Required: cursor_xy=8'h39.
   - Stimulus: read char_xy=8'h0A.
   - Required: char_code=FILL_CHAR.
   - Required: clear takes 40 cycles.
6. Reset mid-clear and same-cell collision:
   - Stimulus: assert rst at clear cycle 100.
   - Required: the clear restarts; cmd_ready rises 256 cycles after rst falls.
   - Stimulus: PUTC to cell 0x25 while char_xy=0x25 in the same cycle.
   - Required: old value on the next cycle, new value one cycle later.
